// File: rtl/piece_scheduler.sv
// Piece scheduler: spawns one piece FSM at a time and forwards its lock as a one-cycle static-array write.
// Latency: lock request sampled at edge N -> En_New_Static high N..N+1; `PIECE_BAG_EN selects 7-bag spawning.
// Backpressure: none; lock requests outside FALL, ticks outside WAIT and START outside IDLE/OVER are dropped.
module piece_scheduler #(
  parameter int NUM_PIECES  = 7,
  parameter int ROW_W       = 5,
  parameter int COL_W       = 4,
  parameter int LOSE_ROW    = 2,
  parameter int SPAWN_DELAY = 2
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_tick,
  input  logic                          START,
  input  logic [2:0]                    randnum,
  input  logic [NUM_PIECES-1:0]         En_New_Static_in,
  input  logic [NUM_PIECES*4*ROW_W-1:0] Row_in,
  input  logic [NUM_PIECES*4*COL_W-1:0] Col_in,
  output logic [NUM_PIECES-1:0]         Active,
  output logic                          En_New_Static,
  output logic [4*ROW_W-1:0]            New_Static_Row,
  output logic [4*COL_W-1:0]            New_Static_col,
  output logic [2:0]                    Next_Piece,
  output logic [2:0]                    Game_State,
  output logic                          Lose,
  output logic [6:0]                    Piece_Count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    LOCK  = 3'd3,
    WAIT  = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_PIECES-1:0]   active_q, active_d;
  logic                    en_q, en_d;
  logic [4*ROW_W-1:0]      row_q, row_d;
  logic [4*COL_W-1:0]      col_q, col_d;
  logic [2:0]              next_q, next_d;
  logic [2:0]              cur_q, cur_d;
  logic                    lose_q, lose_d;
  logic [6:0]              count_q, count_d;
  logic [3:0]              dly_q, dly_d;
  logic                    start_q;

  logic                    start_edge;
  logic [2:0]              base;
  logic [2:0]              pick;
  logic                    take_pick;
  logic                    clr_bag;
  logic                    lock_req;
  logic                    low_row;
  logic [4*ROW_W-1:0]      row_sel;
  logic [4*COL_W-1:0]      col_sel;

  assign start_edge = START & ~start_q;
  assign base       = (randnum == 3'd7) ? 3'd0 : randnum;

`ifdef PIECE_BAG_EN
  logic [6:0] used_q, used_d;
  logic [6:0] avail;
  logic [3:0] sum;
  logic [2:0] idx;
  logic       found;

  // A full mask is treated as empty so the wrap-around pick happens in the same cycle.
  always_comb begin
    avail = (&used_q) ? 7'h7f : ~used_q;
    pick  = base;
    found = 1'b0;
    sum   = 4'd0;
    idx   = 3'd0;
    for (int i = 0; i < 7; i++) begin
      sum = {1'b0, base} + 4'(i);
      if (sum >= 4'd7) sum = sum - 4'd7;
      idx = sum[2:0];
      if (!found && avail[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    used_d = used_q;
    if (clr_bag) used_d = 7'h0;
    else if (take_pick) used_d = ((&used_q) ? 7'h0 : used_q) | (7'h1 << pick);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) used_q <= 7'h0;
    else          used_q <= used_d;
  end
`else
  assign pick = base;
`endif

  always_comb begin
    row_sel  = '0;
    col_sel  = '0;
    lock_req = 1'b0;
    for (int p = 0; p < NUM_PIECES; p++) begin
      if (cur_q == 3'(p)) begin
        row_sel  = Row_in[p*4*ROW_W +: 4*ROW_W];
        col_sel  = Col_in[p*4*COL_W +: 4*COL_W];
        lock_req = En_New_Static_in[p];
      end
    end
  end

  always_comb begin
    low_row = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (row_q[k*ROW_W +: ROW_W] < ROW_W'(LOSE_ROW)) low_row = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    en_d      = 1'b0;
    row_d     = row_q;
    col_d     = col_q;
    next_d    = next_q;
    cur_d     = cur_q;
    lose_d    = lose_q;
    count_d   = count_q;
    dly_d     = dly_q;
    take_pick = 1'b0;
    clr_bag   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          next_d    = pick;
          take_pick = 1'b1;
          state_d   = SPAWN;
        end
      end
      SPAWN: begin
        cur_d     = next_q;
        active_d  = {{(NUM_PIECES-1){1'b0}}, 1'b1} << next_q;
        next_d    = pick;
        take_pick = 1'b1;
        state_d   = FALL;
      end
      FALL: begin
        if (lock_req) begin
          row_d    = row_sel;
          col_d    = col_sel;
          en_d     = 1'b1;
          active_d = '0;
          state_d  = LOCK;
        end
      end
      LOCK: begin
        count_d = (count_q == 7'd127) ? count_q : count_q + 7'd1;
        if (low_row) begin
          lose_d  = 1'b1;
          state_d = OVER;
        end else begin
          dly_d   = 4'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (frame_tick) begin
          dly_d = dly_q + 4'd1;
          if (dly_q + 4'd1 == 4'(SPAWN_DELAY)) state_d = SPAWN;
        end
      end
      OVER: begin
        active_d = '0;
        lose_d   = 1'b1;
        if (start_edge) begin
          lose_d  = 1'b0;
          count_d = 7'd0;
          clr_bag = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      active_q <= '0;
      en_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      next_q   <= 3'd0;
      cur_q    <= 3'd0;
      lose_q   <= 1'b0;
      count_q  <= 7'd0;
      dly_q    <= 4'd0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      en_q     <= en_d;
      row_q    <= row_d;
      col_q    <= col_d;
      next_q   <= next_d;
      cur_q    <= cur_d;
      lose_q   <= lose_d;
      count_q  <= count_d;
      dly_q    <= dly_d;
      start_q  <= START;
    end
  end

  assign Active         = active_q;
  assign En_New_Static  = en_q;
  assign New_Static_Row = row_q;
  assign New_Static_col = col_q;
  assign Next_Piece     = next_q;
  assign Game_State     = state_q;
  assign Lose           = lose_q;
  assign Piece_Count    = count_q;

endmodule

// File: tb/tb_piece_scheduler.sv
// Self-checking bench for piece_scheduler: directed steps plus randomized games against a spawn/lock reference model.
`timescale 1ns/1ps
module tb_piece_scheduler;

  localparam int RW = 5;
  localparam int CW = 4;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         frame_tick;
  logic         START;
  logic [2:0]   randnum;
  logic [6:0]   en_in;
  logic [139:0] row_in;
  logic [111:0] col_in;
  logic [6:0]   Active;
  logic         En_New_Static;
  logic [19:0]  New_Static_Row;
  logic [15:0]  New_Static_col;
  logic [2:0]   Next_Piece;
  logic [2:0]   Game_State;
  logic         Lose;
  logic [6:0]   Piece_Count;

  always #5 Clk = ~Clk;

  piece_scheduler dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .frame_tick      (frame_tick),
    .START           (START),
    .randnum         (randnum),
    .En_New_Static_in(en_in),
    .Row_in          (row_in),
    .Col_in          (col_in),
    .Active          (Active),
    .En_New_Static   (En_New_Static),
    .New_Static_Row  (New_Static_Row),
    .New_Static_col  (New_Static_col),
    .Next_Piece      (Next_Piece),
    .Game_State      (Game_State),
    .Lose            (Lose),
    .Piece_Count     (Piece_Count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: preview/current piece, locked count, bag contents, cell tables.
  int exp_next;
  int exp_cur;
  int exp_cnt;
  bit used [7];
  int rows [7][4];
  int cols [7][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic clear_model();
    exp_cnt = 0;
    foreach (used[i]) used[i] = 1'b0;
  endtask

  task automatic do_pick(input int r, output int p);
    int b;
    b = (r == 7) ? 0 : r;
    p = b;
`ifdef PIECE_BAG_EN
    begin
      int n_used;
      n_used = 0;
      foreach (used[i]) if (used[i]) n_used++;
      if (n_used == 7) foreach (used[i]) used[i] = 1'b0;
      for (int i = 0; i < 7; i++) begin
        if (!used[(b + i) % 7]) begin
          p = (b + i) % 7;
          break;
        end
      end
      used[p] = 1'b1;
    end
`endif
  endtask

  task automatic pack();
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 4; k++) begin
        row_in[(p*4+k)*RW +: RW] = 5'(rows[p][k]);
        col_in[(p*4+k)*CW +: CW] = 4'(cols[p][k]);
      end
    end
  endtask

  task automatic randomize_cells();
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 4; k++) begin
        rows[p][k] = $urandom_range(0, 23);
        cols[p][k] = $urandom_range(0, 15);
      end
    end
  endtask

  task automatic start_game(input int r);
    START = 1'b0;
    step();
    chk("idle_state", Game_State, 0);
    START   = 1'b1;
    randnum = 3'(r);
    step();
    do_pick(r, exp_next);
    chk("start_state", Game_State, 1);
    chk("start_next", Next_Piece, exp_next);
    START = 1'b0;
  endtask

  task automatic restart();
    START = 1'b0;
    step();
    chk("over_hold", Game_State, 5);
    START = 1'b1;
    step();
    clear_model();
    chk("restart_state", Game_State, 0);
    chk("restart_lose", Lose, 0);
    chk("restart_count", Piece_Count, 0);
    START = 1'b0;
  endtask

  // mode 0: normal lock, 1: lock above the lose line, 2: reset while in LOCK. fixed_r < 0 means random randnum.
  task automatic play_piece(input int mode, input int fixed_r);
    int r, n, ticks, idle;
    logic [19:0] er;
    logic [15:0] ec;
    bit low;
    chk("spawn_state", Game_State, 1);
    chk("spawn_active", Active, 0);
    r = (fixed_r < 0) ? $urandom_range(0, 7) : fixed_r;
    randnum = 3'(r);
    step();
    exp_cur = exp_next;
    do_pick(r, exp_next);
    chk("fall_state", Game_State, 2);
    chk("fall_active", Active, 1 << exp_cur);
    chk("fall_next", Next_Piece, exp_next);

    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      en_in      = 7'($urandom) & ~(7'd1 << exp_cur);
      START      = 1'($urandom_range(0, 1));
      randnum    = 3'($urandom);
      frame_tick = 1'($urandom_range(0, 1));
      step();
      chk("fall_hold_state", Game_State, 2);
      chk("fall_hold_active", Active, 1 << exp_cur);
      chk("foreign_req_ignored", En_New_Static, 0);
      chk("fall_hold_next", Next_Piece, exp_next);
    end
    START = 1'b0;
    frame_tick = 1'b0;

    randomize_cells();
    for (int k = 0; k < 4; k++) rows[exp_cur][k] = $urandom_range(2, 23);
    if (mode == 1) rows[exp_cur][$urandom_range(0, 3)] = $urandom_range(0, 1);
    pack();
    for (int k = 0; k < 4; k++) begin
      er[k*RW +: RW] = 5'(rows[exp_cur][k]);
      ec[k*CW +: CW] = 4'(cols[exp_cur][k]);
    end
    en_in = 7'($urandom) | (7'd1 << exp_cur);
    step();
    chk("lock_strobe", En_New_Static, 1);
    chk("lock_state", Game_State, 3);
    chk("lock_active", Active, 0);
    chk("lock_row", New_Static_Row, er);
    chk("lock_col", New_Static_col, ec);
    en_in = 7'd0;

    if (mode == 2) begin
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_strobe_async", En_New_Static, 0);
      chk("rst_state_async", Game_State, 0);
      chk("rst_count_async", Piece_Count, 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      clear_model();
      exp_next = 0;
      return;
    end

    step();
    if (exp_cnt < 127) exp_cnt++;
    chk("strobe_one_cycle", En_New_Static, 0);
    chk("piece_count", Piece_Count, exp_cnt);
    low = 1'b0;
    for (int k = 0; k < 4; k++) if (rows[exp_cur][k] < 2) low = 1'b1;
    if (low) begin
      chk("over_state", Game_State, 5);
      chk("over_lose", Lose, 1);
      chk("over_active", Active, 0);
      return;
    end
    chk("wait_state", Game_State, 4);
    chk("wait_lose", Lose, 0);

    ticks = 0;
    idle  = 0;
    while (ticks < 2) begin
      frame_tick = ($urandom_range(0, 1) == 1) || (idle >= 6);
      en_in      = 7'($urandom);
      START      = 1'($urandom_range(0, 1));
      step();
      if (frame_tick) begin
        ticks++;
        idle = 0;
      end else begin
        idle++;
      end
      chk("wait_pacing", Game_State, (ticks < 2) ? 4 : 1);
    end
    frame_tick = 1'b0;
    en_in      = 7'd0;
    START      = 1'b0;
  endtask

  initial begin
    logic [19:0] dir_rows;
    Reset_n    = 1'b0;
    START      = 1'b0;
    frame_tick = 1'b0;
    randnum    = 3'd0;
    en_in      = 7'd0;
    row_in     = '0;
    col_in     = '0;
    clear_model();
    exp_next = 0;
    repeat (2) @(negedge Clk);
    chk("reset_state", Game_State, 0);
    chk("reset_active", Active, 0);
    chk("reset_lose", Lose, 0);
    chk("reset_count", Piece_Count, 0);
    chk("reset_strobe", En_New_Static, 0);
    chk("reset_next", Next_Piece, 0);
    chk("reset_row", New_Static_Row, 0);
    Reset_n = 1'b1;
    step();

    // Directed: START with randnum 3, then 5 at SPAWN; lock piece 3 at rows {10,10,11,11}.
    START   = 1'b1;
    randnum = 3'd3;
    step();
    do_pick(3, exp_next);
    chk("dir_spawn_state", Game_State, 1);
    chk("dir_spawn_next", Next_Piece, 3);
    START   = 1'b0;
    randnum = 3'd5;
    step();
    exp_cur = exp_next;
    do_pick(5, exp_next);
    chk("dir_active", Active, 7'b0001000);
    chk("dir_next", Next_Piece, 5);
    chk("dir_fall", Game_State, 2);
    en_in = 7'b0000100;
    step();
    chk("dir_foreign_strobe", En_New_Static, 0);
    chk("dir_foreign_state", Game_State, 2);
    randomize_cells();
    rows[3][0] = 10; rows[3][1] = 10; rows[3][2] = 11; rows[3][3] = 11;
    pack();
    en_in = 7'b0001000;
    step();
    dir_rows = {5'd11, 5'd11, 5'd10, 5'd10};
    chk("dir_strobe", En_New_Static, 1);
    chk("dir_rows", New_Static_Row, dir_rows);
    chk("dir_lock_active", Active, 0);
    en_in = 7'd0;
    step();
    exp_cnt = 1;
    chk("dir_strobe_drop", En_New_Static, 0);
    chk("dir_wait", Game_State, 4);
    frame_tick = 1'b1; step(); chk("dir_tick1", Game_State, 4);
    frame_tick = 1'b0; step(); chk("dir_gap", Game_State, 4);
    frame_tick = 1'b1; step(); chk("dir_tick2", Game_State, 1);
    frame_tick = 1'b0;
    chk("dir_count", Piece_Count, 1);

    // Continue this game randomly, then lose.
    repeat (3) play_piece(0, -1);
    play_piece(1, -1);
    restart();

    // randnum held at 7.
    start_game(7);
    repeat (8) play_piece(0, 7);
    play_piece(1, 7);
    restart();

    // Randomized games.
    for (int g = 0; g < 4; g++) begin
      start_game($urandom_range(0, 7));
      repeat ($urandom_range(1, 10)) play_piece(0, -1);
      play_piece(1, -1);
      restart();
    end

    // Piece_Count saturation.
    start_game($urandom_range(0, 7));
    repeat (130) play_piece(0, -1);
    chk("count_saturated", Piece_Count, 127);
    play_piece(1, -1);
    chk("count_saturated_lose", Piece_Count, 127);
    restart();

    // Reset asserted while in LOCK.
    start_game($urandom_range(0, 7));
    play_piece(0, -1);
    play_piece(2, -1);
    step();
    chk("post_reset_state", Game_State, 0);
    chk("post_reset_next", Next_Piece, exp_next);
    start_game($urandom_range(0, 7));
    play_piece(0, -1);
    chk("post_reset_count", Piece_Count, exp_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
